// File: rtl/sram_bank.sv
// sram_bank: single-clock, one-read/one-write SRAM bank with per-byte write
// enables, hardware zero-fill (after reset and on clear_req) and a one-cycle
// read-valid handshake.
// Build option: define SRAM_BYPASS_EN for write-first same-address collisions;
// left undefined the bank is read-first.
module sram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 1024,
    localparam int LOGDEPTH  = $clog2(DEPTH),
    localparam int NBYTES    = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_busy,
    input  logic                  clear_req,
    input  logic                  read_req,
    input  logic [LOGDEPTH-1:0]   read_addr,
    output logic                  read_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_req,
    input  logic [LOGDEPTH-1:0]   write_addr,
    input  logic [NBYTES-1:0]     write_byte_en,
    input  logic [DATA_WIDTH-1:0] write_data
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [LOGDEPTH-1:0] FILL_LAST = LOGDEPTH'(DEPTH - 1);
    localparam logic [LOGDEPTH:0]   DEPTH_EXT = (LOGDEPTH + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [LOGDEPTH-1:0] fill_cnt;
    logic [LOGDEPTH-1:0] fill_cnt_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // Addresses past DEPTH are representable when DEPTH is not a power of two.
    assign rd_in_range = {1'b0, read_addr}  < DEPTH_EXT;
    assign wr_in_range = {1'b0, write_addr} < DEPTH_EXT;

    // Requests only take effect in READY; in CLEAR they are silently dropped.
    assign rd_fire = (state == READY) && read_req;
    assign wr_fire = (state == READY) && write_req && wr_in_range;

    assign init_busy = (state == CLEAR);

    // State and fill-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
        end
    end

    // Next state: sweep every word once in CLEAR, then serve traffic in READY.
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        case (state)
            CLEAR: begin
                if (fill_cnt == FILL_LAST) begin
                    state_nxt    = READY;
                    fill_cnt_nxt = '0;
                end else begin
                    fill_cnt_nxt = fill_cnt + LOGDEPTH'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end
            end
            default: begin
                state_nxt    = CLEAR;
                fill_cnt_nxt = '0;
            end
        endcase
    end

    // Storage: the fill sweep owns the write port in CLEAR, byte-lane writes in READY.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[fill_cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (write_byte_en[i]) begin
                    mem[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign mem_rd = rd_in_range ? mem[read_addr] : '0;

`ifdef SRAM_BYPASS_EN
    // Enabled lanes take the incoming write data, the rest keep the stored word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     lane_en
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (lane_en[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return merged;
    endfunction

    // wr_fire already implies an in-range address, so out-of-range reads never merge.
    logic collide;
    assign collide = wr_fire && (write_addr == read_addr);
    assign rd_word = collide ? merge_lanes(mem_rd, write_data, write_byte_en) : mem_rd;
`else
    // Read-first: a colliding write becomes visible on the following cycle.
    assign rd_word = mem_rd;
`endif

    // ---- read stage p0 -> p1 ----
    // Capture the read result; read_data holds between completed reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire) begin
                rd_data_p1 <= rd_word;
            end
        end
    end

    assign read_valid = vld_p1;
    assign read_data  = rd_data_p1;

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: table-driven bench for sram_bank (DEPTH=16, 32-bit words, 8-bit
// lanes) plus a DEPTH=12 instance for out-of-range addresses.
module tb_sram_bank;

    logic clk;
    logic reset;

    // Main instance, DEPTH = 16
    logic        init_busy;
    logic        clear_req;
    logic        read_req;
    logic [3:0]  read_addr;
    logic        read_valid;
    logic [31:0] read_data;
    logic        write_req;
    logic [3:0]  write_addr;
    logic [3:0]  write_byte_en;
    logic [31:0] write_data;

    // Second instance, DEPTH = 12 (addresses 12..15 are out of range)
    logic        u1_init_busy;
    logic        u1_clear_req;
    logic        u1_read_req;
    logic [3:0]  u1_read_addr;
    logic        u1_read_valid;
    logic [31:0] u1_read_data;
    logic        u1_write_req;
    logic [3:0]  u1_write_addr;
    logic [3:0]  u1_write_byte_en;
    logic [31:0] u1_write_data;

    sram_bank #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(16)) u0 (
        .clk(clk), .reset(reset), .init_busy(init_busy), .clear_req(clear_req),
        .read_req(read_req), .read_addr(read_addr), .read_valid(read_valid),
        .read_data(read_data), .write_req(write_req), .write_addr(write_addr),
        .write_byte_en(write_byte_en), .write_data(write_data)
    );

    sram_bank #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(12)) u1 (
        .clk(clk), .reset(reset), .init_busy(u1_init_busy), .clear_req(u1_clear_req),
        .read_req(u1_read_req), .read_addr(u1_read_addr), .read_valid(u1_read_valid),
        .read_data(u1_read_data), .write_req(u1_write_req), .write_addr(u1_write_addr),
        .write_byte_en(u1_write_byte_en), .write_data(u1_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SRAM_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'hAAAA5555;
`else
    localparam logic [31:0] COLL_EXP = 32'hAAAAAAAA;
`endif

    typedef struct {
        string       nm;
        logic        clr;
        logic        rd;
        logic [3:0]  ra;
        logic        wr;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        ev;   // read_valid expected after the edge
        logic        ec;   // read_data checked even when ev = 0
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        string       nm;
        logic        ev;
        logic        ec;
        logic [31:0] ed;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string nm, input logic clr, input logic rd,
                                input logic [3:0] ra, input logic wr, input logic [3:0] wa,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic ev, input logic ec, input logic [31:0] ed);
        vec_t v;
        v.nm = nm; v.clr = clr; v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa;
        v.be = be; v.wd = wd; v.ev = ev; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus on u0, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        clear_req     = v.clr;
        read_req      = v.rd;
        read_addr     = v.ra;
        write_req     = v.wr;
        write_addr    = v.wa;
        write_byte_en = v.be;
        write_data    = v.wd;
        e.nm = v.nm; e.ev = v.ev; e.ec = v.ec; e.ed = v.ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        read_req  = 1'b0;
        write_req = 1'b0;
        e = sb.pop_front();
        cmp({e.nm, " valid"}, {31'b0, read_valid}, {31'b0, e.ev});
        if (e.ev || e.ec) cmp({e.nm, " data"}, read_data, e.ed);
    endtask

    // Idle cycles (with optional injections during the first fill) until both
    // banks leave CLEAR; returns the edge index at which each dropped busy.
    task automatic wait_fill(input bit inject, output int n0, output int n1);
        int c;
        c = 0; n0 = 0; n1 = 0;
        while ((n0 == 0 || n1 == 0) && c < 40) begin
            if (inject && c == 4)
                apply(mk("clear rd/wr 15", 0, 1, 4'd15, 1, 4'd15, 4'hF, 32'hFFFFFFFF, 0, 0, 0));
            else if (inject && c == 5)
                apply(mk("clear rd/wr 1", 0, 1, 4'd1, 1, 4'd1, 4'hF, 32'hFFFFFFFF, 0, 0, 0));
            else
                apply(mk("fill idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            c++;
            if (!init_busy && n0 == 0) n0 = c;
            if (!u1_init_busy && n1 == 0) n1 = c;
        end
    endtask

    initial begin
        int n0;
        int n1;

        // ---- vector table for READY traffic ----
        tbl.push_back(mk("wr5 full",     0, 0, 0,     1, 4'd5,  4'hF, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk("wr5 lanes02",  0, 0, 0,     1, 4'd5,  4'h5, 32'h11223344, 0, 0, 0));
        tbl.push_back(mk("rd5 merged",   0, 1, 4'd5,  0, 0,     0,    0,            1, 0, 32'hDE22BE44));
        tbl.push_back(mk("b2b rd3",      0, 1, 4'd3,  0, 0,     0,    0,            1, 0, 32'h00000000));
        tbl.push_back(mk("b2b rd4",      0, 1, 4'd4,  0, 0,     0,    0,            1, 0, 32'h00000000));
        tbl.push_back(mk("b2b rd5",      0, 1, 4'd5,  0, 0,     0,    0,            1, 0, 32'hDE22BE44));
        tbl.push_back(mk("hold idle",    0, 0, 0,     0, 0,     0,    0,            0, 1, 32'hDE22BE44));
        tbl.push_back(mk("wr7 A",        0, 0, 0,     1, 4'd7,  4'hF, 32'hAAAAAAAA, 0, 0, 0));
        tbl.push_back(mk("coll rd/wr7",  0, 1, 4'd7,  1, 4'd7,  4'h3, 32'h55555555, 1, 0, COLL_EXP));
        tbl.push_back(mk("rd7 after",    0, 1, 4'd7,  0, 0,     0,    0,            1, 0, 32'hAAAA5555));
        tbl.push_back(mk("wr9 no lanes", 0, 0, 0,     1, 4'd9,  4'h0, 32'hFFFFFFFF, 0, 0, 0));
        tbl.push_back(mk("rd9 zero",     0, 1, 4'd9,  0, 0,     0,    0,            1, 0, 32'h00000000));
        tbl.push_back(mk("wr10 rd5",     0, 1, 4'd5,  1, 4'd10, 4'hF, 32'h12345678, 1, 0, 32'hDE22BE44));
        tbl.push_back(mk("rd10",         0, 1, 4'd10, 0, 0,     0,    0,            1, 0, 32'h12345678));
        tbl.push_back(mk("rd15 dropped", 0, 1, 4'd15, 0, 0,     0,    0,            1, 0, 32'h00000000));
        tbl.push_back(mk("rd1 dropped",  0, 1, 4'd1,  0, 0,     0,    0,            1, 0, 32'h00000000));
        tbl.push_back(mk("idle",         0, 0, 0,     0, 0,     0,    0,            0, 0, 0));

        reset = 1'b1;
        clear_req = 0; read_req = 0; read_addr = 0; write_req = 0;
        write_addr = 0; write_byte_en = 0; write_data = 0;
        u1_clear_req = 0; u1_read_req = 0; u1_read_addr = 0; u1_write_req = 0;
        u1_write_addr = 0; u1_write_byte_en = 0; u1_write_data = 0;

        // ---- reset state ----
        @(posedge clk);
        #1;
        cmp("reset init_busy",  {31'b0, init_busy},  32'd1);
        cmp("reset read_valid", {31'b0, read_valid}, 32'd0);
        cmp("reset read_data",  read_data,           32'd0);
        reset = 1'b0;

        // ---- initial fill, with requests injected while in CLEAR ----
        wait_fill(1'b1, n0, n1);
        cmp("fill cycles d16", n0, 32'd16);
        cmp("fill cycles d12", n1, 32'd12);

        // ---- every word reads zero after the fill ----
        for (int a = 0; a < 16; a++)
            apply(mk($sformatf("zero rd%0d", a), 0, 1, 4'(a), 0, 0, 0, 0, 1, 0, 32'h0));

        // ---- out-of-range handling on the DEPTH=12 bank ----
        u1_write_req = 1; u1_write_addr = 4'd14; u1_write_byte_en = 4'hF; u1_write_data = 32'hFFFFFFFF;
        u1_read_req = 1; u1_read_addr = 4'd14;
        @(posedge clk);
        #1;
        u1_write_req = 0; u1_read_req = 0;
        cmp("u1 oor coll valid", {31'b0, u1_read_valid}, 32'd1);
        cmp("u1 oor coll data",  u1_read_data,           32'd0);
        u1_write_req = 1; u1_write_addr = 4'd11; u1_write_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        u1_write_req = 0;
        cmp("u1 wr valid low", {31'b0, u1_read_valid}, 32'd0);
        u1_read_req = 1; u1_read_addr = 4'd11;
        @(posedge clk);
        #1;
        cmp("u1 rd11 valid", {31'b0, u1_read_valid}, 32'd1);
        cmp("u1 rd11 data",  u1_read_data,           32'hCAFEF00D);
        u1_read_addr = 4'd15;
        @(posedge clk);
        #1;
        u1_read_req = 0;
        cmp("u1 rd15 valid", {31'b0, u1_read_valid}, 32'd1);
        cmp("u1 rd15 data",  u1_read_data,           32'd0);

        // ---- table-driven READY traffic ----
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // ---- clear_req with traffic, then reset at fill count 8 ----
        apply(mk("clr wr2 rd5", 1, 1, 4'd5, 1, 4'd2, 4'hF, 32'h12345678, 1, 0, 32'hDE22BE44));
        cmp("clr init_busy", {31'b0, init_busy}, 32'd1);
        for (int i = 0; i < 8; i++)
            apply(mk("refill idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDE22BE44));
        reset = 1'b1;
        #1;
        cmp("async rst init_busy",  {31'b0, init_busy},  32'd1);
        cmp("async rst read_valid", {31'b0, read_valid}, 32'd0);
        cmp("async rst read_data",  read_data,           32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_fill(1'b0, n0, n1);
        cmp("refill cycles d16", n0, 32'd16);
        cmp("refill cycles d12", n1, 32'd12);
        apply(mk("rd2 cleared",  0, 1, 4'd2,  0, 0, 0, 0, 1, 0, 32'h0));
        apply(mk("rd5 cleared",  0, 1, 4'd5,  0, 0, 0, 0, 1, 0, 32'h0));
        apply(mk("rd10 cleared", 0, 1, 4'd10, 0, 0, 0, 0, 1, 0, 32'h0));
        apply(mk("rd15 cleared", 0, 1, 4'd15, 0, 0, 0, 0, 1, 0, 32'h0));
        apply(mk("final idle",   0, 0, 0,     0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
